// File: rtl/cu_arb_pkg.sv
// cu_arbiter shared definitions.
// Widths and the {id, rd} result tag.
package cu_arb_pkg;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;
  localparam int ID_MAX = 2;

  typedef struct packed {
    logic [ID_MAX-1:0] id;
    logic [RD_W-1:0]   rd;
  } tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int n);
    return id_w(n) + RD_W;
  endfunction
endpackage

// File: rtl/cu_arb_if.sv
// Requester, custom-unit and writeback
// signals of cu_arbiter.
interface cu_arb_if
  import cu_arb_pkg::*;
#(
  parameter int NREQ = 2
) ();
  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]        req_v;
  logic [NREQ*RD_W-1:0]   req_rd;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cu_in_v;
  logic [RD_W-1:0]        cu_rd;
  logic [DATA_W-1:0]      cu_in_data;
  logic                   cu_busy;
  logic                   cu_out_v;
  logic [RD_W-1:0]        cu_out_rd;
  logic [DATA_W-1:0]      cu_out_data;
  logic                   wb_v;
  logic [ID_W-1:0]        wb_id;
  logic [RD_W-1:0]        wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic                   err;

  modport slave (
    input  req_v, req_rd, req_data,
    input  cu_busy, cu_out_v,
    input  cu_out_rd, cu_out_data,
    output req_ready, cu_in_v,
    output cu_rd, cu_in_data,
    output wb_v, wb_id, wb_rd,
    output wb_data, err
  );

  modport master (
    output req_v, req_rd, req_data,
    output cu_busy, cu_out_v,
    output cu_out_rd, cu_out_data,
    input  req_ready, cu_in_v,
    input  cu_rd, cu_in_data,
    input  wb_v, wb_id, wb_rd,
    input  wb_data, err
  );
endinterface

// File: rtl/cu_tag_fifo.sv
// In-order tag FIFO: remembers which
// requester owns each in-flight op.
module cu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // next pointers and occupancy
  always_comb begin
    wp_d  = push_i ? wp_q + 1'b1 : wp_q;
    rp_d  = pop_i ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer state, flushed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // storage, needs no reset
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/cu_arbiter.sv
// Round-robin share of one custom unit
// with in-order result routing.
module cu_arbiter
  import cu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAX_OUT = 4
) (
  input logic     clk,
  input logic     reset,
  cu_arb_if.slave bus
);
  localparam int ID_W  = id_w(NREQ);
  localparam int TAG_W = tag_w(NREQ);

  logic              full, empty;
  logic [TAG_W-1:0]  head;
  logic [ID_W-1:0]   head_id;
  logic [RD_W-1:0]   head_rd;
  logic              can_issue;
  logic              any;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   gnt_id;
  logic [RD_W-1:0]   sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              pop;

  logic              cv_q, cv_d;
  logic [RD_W-1:0]   crd_q, crd_d;
  logic [DATA_W-1:0] cdat_q, cdat_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              wv_q, wv_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [RD_W-1:0]   wrd_q, wrd_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              err_q, err_d;

  assign can_issue = !bus.cu_busy
                   && !full && !reset;

  // first valid requester from ptr, wrapping
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    gnt_id = '0;
    if (can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = ID_W'((int'(ptr_q) + k) % NREQ);
        if (!any && bus.req_v[idx]) begin
          any    = 1'b1;
          gnt_id = idx;
        end
      end
    end
  end

  assign bus.req_ready = any
    ? (NREQ'(1) << gnt_id) : '0;

  // fields of the granted requester
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_rd   = bus.req_rd[i*RD_W +: RD_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pop     = bus.cu_out_v && !empty;
  assign head_id = head[RD_W +: ID_W];
  assign head_rd = head[RD_W-1:0];

  cu_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TAG_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (any),
    .din_i   ({gnt_id, sel_rd}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // issue, pointer, writeback and error next state
  always_comb begin
    cv_d   = any;
    crd_d  = crd_q;
    cdat_d = cdat_q;
    ptr_d  = ptr_q;
    wv_d   = pop;
    wid_d  = wid_q;
    wrd_d  = wrd_q;
    wdat_d = wdat_q;
    err_d  = err_q;
    if (any) begin
      crd_d  = sel_rd;
      cdat_d = sel_data;
      ptr_d  = (gnt_id == ID_W'(NREQ-1))
             ? '0 : gnt_id + 1'b1;
    end
    if (pop) begin
      wid_d  = head_id;
      wrd_d  = bus.cu_out_rd;
      wdat_d = bus.cu_out_data;
      if (head_rd != bus.cu_out_rd)
        err_d = 1'b1;
    end
    if (bus.cu_out_v && empty)
      err_d = 1'b1;
  end

  // registered issue and writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      cv_q   <= 1'b0;
      crd_q  <= '0;
      cdat_q <= '0;
      ptr_q  <= '0;
      wv_q   <= 1'b0;
      wid_q  <= '0;
      wrd_q  <= '0;
      wdat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cv_q   <= cv_d;
      crd_q  <= crd_d;
      cdat_q <= cdat_d;
      ptr_q  <= ptr_d;
      wv_q   <= wv_d;
      wid_q  <= wid_d;
      wrd_q  <= wrd_d;
      wdat_q <= wdat_d;
      err_q  <= err_d;
    end
  end

  assign bus.cu_in_v    = cv_q;
  assign bus.cu_rd      = crd_q;
  assign bus.cu_in_data = cdat_q;
  assign bus.wb_v       = wv_q;
  assign bus.wb_id      = wid_q;
  assign bus.wb_rd      = wrd_q;
  assign bus.wb_data    = wdat_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_cu_arbiter.sv
// Bench for cu_arbiter with an increment
// unit model and writeback scoreboard.
module tb_cu_arbiter;
  import cu_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cu_arb_if #(.NREQ(NREQ)) bus ();

  cu_arbiter #(
    .NREQ    (NREQ),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // unit model: result = operand + 1 after lat cycles
  int          lat = 1;
  logic        manual = 1'b0;
  logic        m_v = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_d = '0;
  logic        pv [4];
  logic [4:0]  prd [4];
  logic [31:0] pd [4];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else begin
      pv[0]  <= bus.cu_in_v;
      prd[0] <= bus.cu_rd;
      pd[0]  <= bus.cu_in_data + 32'd1;
      for (int i = 1; i < 4; i++) begin
        pv[i]  <= pv[i-1];
        prd[i] <= prd[i-1];
        pd[i]  <= pd[i-1];
      end
    end
  end

  assign bus.cu_out_v    = manual ? m_v  : pv[lat-1];
  assign bus.cu_out_rd   = manual ? m_rd : prd[lat-1];
  assign bus.cu_out_data = manual ? m_d  : pd[lat-1];

  // scoreboard: push on accept, pop on writeback
  typedef struct packed {
    logic [0:0]  id;
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;
  exp_t q [$];
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else if (!manual) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_v[i] && bus.req_ready[i])
          q.push_back('{1'(i),
                        bus.req_rd[i*5 +: 5],
                        bus.req_data[i*32 +: 32] + 32'd1});
      end
      if (bus.wb_v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got wb id %0d want none",
                   bus.wb_id);
        end else begin
          e = q.pop_front();
          chk("sb_id", 32'(bus.wb_id), 32'(e.id));
          chk("sb_rd", 32'(bus.wb_rd), 32'(e.rd));
          chk("sb_data", bus.wb_data, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_cu_in_v"}, 32'(bus.cu_in_v), 0);
    chk({tag, "_cu_rd"}, 32'(bus.cu_rd), 0);
    chk({tag, "_cu_data"}, bus.cu_in_data, 0);
    chk({tag, "_wb_v"}, 32'(bus.wb_v), 0);
    chk({tag, "_wb_id"}, 32'(bus.wb_id), 0);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  task automatic single_op(input string tag);
    bus.req_v = 2'b01;
    bus.req_rd[4:0] = 5'd3;
    bus.req_data[31:0] = 32'd10;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.req_ready), 1);
    step();
    bus.req_v = 2'b00;
    @(negedge clk);
    chk({tag, "_cu_in_v"}, 32'(bus.cu_in_v), 1);
    chk({tag, "_cu_rd"}, 32'(bus.cu_rd), 3);
    chk({tag, "_cu_data"}, bus.cu_in_data, 10);
    step();
    @(negedge clk);
    chk({tag, "_cu_out_v"}, 32'(bus.cu_out_v), 1);
    chk({tag, "_wb_early"}, 32'(bus.wb_v), 0);
    step();
    @(negedge clk);
    chk({tag, "_wb_v"}, 32'(bus.wb_v), 1);
    chk({tag, "_wb_id"}, 32'(bus.wb_id), 0);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 3);
    chk({tag, "_wb_data"}, bus.wb_data, 11);
    chk({tag, "_err"}, 32'(bus.err), 0);
    step();
    @(negedge clk);
    chk({tag, "_wb_pulse"}, 32'(bus.wb_v), 0);
    step();
  endtask

  typedef struct {
    logic [1:0] v;
    logic       busy;
    logic [1:0] rdy;
  } vec_t;
  vec_t tv [12];

  initial begin
    tv[0]  = '{2'b00, 1'b0, 2'b00};
    tv[1]  = '{2'b11, 1'b0, 2'b01};
    tv[2]  = '{2'b11, 1'b0, 2'b10};
    tv[3]  = '{2'b11, 1'b0, 2'b01};
    tv[4]  = '{2'b11, 1'b0, 2'b10};
    tv[5]  = '{2'b01, 1'b0, 2'b01};
    tv[6]  = '{2'b01, 1'b0, 2'b01};
    tv[7]  = '{2'b10, 1'b1, 2'b00};
    tv[8]  = '{2'b10, 1'b1, 2'b00};
    tv[9]  = '{2'b10, 1'b1, 2'b00};
    tv[10] = '{2'b10, 1'b0, 2'b10};
    tv[11] = '{2'b00, 1'b0, 2'b00};

    bus.req_v    = 2'b11;
    bus.req_rd   = '0;
    bus.req_data = '0;
    bus.cu_busy  = 1'b0;

    // reset state, requests held high
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    chk_reset_outs("rst");
    step();
    reset = 1'b0;
    bus.req_v = 2'b00;

    // grant table: rotation, fall-through, busy
    for (int i = 0; i < 12; i++) begin
      bus.req_v   = tv[i].v;
      bus.cu_busy = tv[i].busy;
      bus.req_rd  = {5'(i + 10), 5'(i)};
      bus.req_data = {32'(i * 100 + 1),
                      32'(i * 100)};
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i),
          32'(bus.req_ready), 32'(tv[i].rdy));
      step();
    end
    bus.req_v = 2'b00;
    bus.cu_busy = 1'b0;
    repeat (6) step();
    chk("tv_drain", 32'(q.size()), 0);

    single_op("one");

    // full: four accepts, then stall until first result
    lat = 4;
    bus.req_v = 2'b01;
    bus.req_rd[4:0] = 5'd5;
    bus.req_data[31:0] = 32'd50;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("full%0d_ready", c),
          32'(bus.req_ready),
          (c < 4 || c == 6) ? 32'd1 : 32'd0);
      if (c == 4 || c == 5)
        chk($sformatf("full%0d_out_v", c),
            32'(bus.cu_out_v),
            (c == 5) ? 32'd1 : 32'd0);
      step();
    end
    bus.req_v = 2'b00;
    repeat (12) step();
    chk("full_drain", 32'(q.size()), 0);
    lat = 1;

    // error: result with nothing outstanding
    manual = 1'b1;
    m_v = 1'b1;
    m_rd = 5'd1;
    m_d = 32'd99;
    step();
    m_v = 1'b0;
    @(negedge clk);
    chk("empty_err", 32'(bus.err), 1);
    chk("empty_wb_v", 32'(bus.wb_v), 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("empty_err_clr", 32'(bus.err), 0);
    step();

    // error: rd mismatch still writes back
    bus.req_v = 2'b01;
    bus.req_rd[4:0] = 5'd7;
    bus.req_data[31:0] = 32'd5;
    step();
    bus.req_v = 2'b00;
    step();
    step();
    m_v = 1'b1;
    m_rd = 5'd9;
    m_d = 32'd42;
    step();
    m_v = 1'b0;
    @(negedge clk);
    chk("mis_wb_v", 32'(bus.wb_v), 1);
    chk("mis_wb_id", 32'(bus.wb_id), 0);
    chk("mis_wb_rd", 32'(bus.wb_rd), 9);
    chk("mis_wb_data", bus.wb_data, 42);
    chk("mis_err", 32'(bus.err), 1);
    repeat (3) step();
    @(negedge clk);
    chk("mis_err_sticky", 32'(bus.err), 1);
    chk("mis_wb_pulse", 32'(bus.wb_v), 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    manual = 1'b0;
    @(negedge clk);
    chk("mis_err_clr", 32'(bus.err), 0);
    step();

    // reset with three ops from requester 1 in flight
    lat = 4;
    bus.req_v = 2'b10;
    bus.req_rd[9:5] = 5'd20;
    bus.req_data[63:32] = 32'd300;
    repeat (3) step();
    bus.req_v = 2'b01;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    step();
    reset = 1'b0;
    bus.req_v = 2'b00;
    @(negedge clk);
    chk_reset_outs("mid");
    lat = 1;
    step();
    step();
    single_op("post");
    repeat (4) step();
    chk("end_drain", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
